sdr_cas_rd_capture: RTL and testbench

Read-data capture stage of the SDRAM controller, directly downstream of the CAS configuration interface; it consumes cfg_sdr_cas. It tracks each READ issued to the device, waits the configured CAS latency, then samples the DQ bus for the burst. It presents registered read data with valid, last and tag to the host-side read path. It also honours SDRAM read-interrupts-read semantics.

---
 rtl/sdr_cas_pkg.sv | 23 ++
 rtl/sdr_rd_delay_line.sv | 37 +++
 rtl/sdr_cas_rd_capture.sv | 111 +++++++++++
 tb/tb_sdr_cas_rd_capture.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sdr_cas_pkg.sv
// Shared constants, types and helpers for the SDRAM read-capture path.
package sdr_cas_pkg;

  localparam int CAS_MIN  = 2;
  localparam int CAS_MAX  = 3;
  localparam int RD_BL_W  = 3;
  localparam int RD_TAG_W = 4;

  typedef logic [2:0] cas_t;

  // One READ travelling down the CAS delay line.
  typedef struct packed {
    logic                vld;
    logic [RD_BL_W-1:0]  len;
    logic [RD_TAG_W-1:0] tag;
  } rd_token_t;

  // True when the requested CAS latency lies inside the supported window.
  function automatic logic cas_legal(input cas_t value, input int lo, input int hi);
    return (int'(value) >= lo) && (int'(value) <= hi);
  endfunction

endpackage

// File: rtl/sdr_rd_delay_line.sv
// Shift register of READ tokens with a tap chosen by the latched CAS latency.
module sdr_rd_delay_line
  import sdr_cas_pkg::*;
#(
  parameter int DEPTH = CAS_MAX
) (
  input  logic      i_clk,
  input  logic      i_reset,
  input  rd_token_t i_token,
  input  cas_t      i_tap_sel,
  output rd_token_t o_tap,
  output logic      o_any_vld
);

  rd_token_t r_stage [DEPTH];

  // Advance every token one stage per clock; stage 0 holds the token issued last cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < DEPTH; k++) r_stage[k] <= '0;
    end else begin
      r_stage[0] <= i_token;
      for (int k = 1; k < DEPTH; k++) r_stage[k] <= r_stage[k-1];
    end
  end

  // Select the tap (stage number equals latency) and flag any token still in flight.
  always_comb begin
    o_tap     = '0;
    o_any_vld = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (int'(i_tap_sel) == k + 1) o_tap = r_stage[k];
      o_any_vld = o_any_vld | r_stage[k].vld;
    end
  end

endmodule

// File: rtl/sdr_cas_rd_capture.sv
// Read-data capture: delays each READ by the CAS latency, then samples the burst off DQ.
module sdr_cas_rd_capture #(
  parameter int DW      = 16,
  parameter int BL_W    = sdr_cas_pkg::RD_BL_W,
  parameter int TAG_W   = sdr_cas_pkg::RD_TAG_W,
  parameter int CAS_MIN = sdr_cas_pkg::CAS_MIN,
  parameter int CAS_MAX = sdr_cas_pkg::CAS_MAX
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [2:0]       i_cfg_sdr_cas,
  input  logic             i_rd_cmd,
  input  logic [BL_W-1:0]  i_rd_len,
  input  logic [TAG_W-1:0] i_rd_tag,
  input  logic [DW-1:0]    i_sdr_dq_in,
  output logic [DW-1:0]    o_rd_data,
  output logic             o_rd_data_valid,
  output logic             o_rd_data_last,
  output logic [TAG_W-1:0] o_rd_data_tag,
  output logic             o_pipe_busy,
  output logic             o_cas_cfg_err
);

  import sdr_cas_pkg::*;

  cas_t             r_cas_lat;
  logic             r_cas_cfg_err;
  logic [BL_W-1:0]  r_beats_left;
  logic [DW-1:0]    r_rd_data;
  logic             r_rd_valid;
  logic             r_rd_last;
  logic [TAG_W-1:0] r_rd_tag;

  rd_token_t        w_in_tok;
  rd_token_t        w_tap;
  logic             w_line_busy;
  logic             w_pipe_busy;

  // Package the incoming command as a token for the delay line.
  always_comb begin
    w_in_tok     = '0;
    w_in_tok.vld = i_rd_cmd;
    w_in_tok.len = i_rd_len;
    w_in_tok.tag = i_rd_tag;
  end

  sdr_rd_delay_line #(
    .DEPTH (CAS_MAX)
  ) u_delay_line (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_token   (w_in_tok),
    .i_tap_sel (r_cas_lat),
    .o_tap     (w_tap),
    .o_any_vld (w_line_busy)
  );

  // Busy covers tokens in the line, remaining beats, and the beat currently presented.
  always_comb begin
    w_pipe_busy = w_line_busy | (r_beats_left != '0) | r_rd_valid;
  end

  // Latency only changes when nothing is in flight, so a burst never sees it move.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cas_lat     <= cas_t'(CAS_MAX);
      r_cas_cfg_err <= 1'b0;
    end else if (!w_pipe_busy && !i_rd_cmd) begin
      if (cas_legal(i_cfg_sdr_cas, CAS_MIN, CAS_MAX)) begin
        r_cas_lat     <= i_cfg_sdr_cas;
        r_cas_cfg_err <= 1'b0;
      end else begin
        r_cas_lat     <= cas_t'(CAS_MAX);
        r_cas_cfg_err <= 1'b1;
      end
    end
  end

  // Burst engine: a fresh tap always wins, which aborts any burst still running.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_beats_left <= '0;
      r_rd_data    <= '0;
      r_rd_valid   <= 1'b0;
      r_rd_last    <= 1'b0;
      r_rd_tag     <= '0;
    end else if (w_tap.vld) begin
      r_rd_data    <= i_sdr_dq_in;
      r_rd_valid   <= 1'b1;
      r_rd_last    <= (w_tap.len == '0);
      r_rd_tag     <= w_tap.tag;
      r_beats_left <= w_tap.len;
    end else if (r_beats_left != '0) begin
      r_rd_data    <= i_sdr_dq_in;
      r_rd_valid   <= 1'b1;
      r_rd_last    <= (r_beats_left == BL_W'(1));
      r_beats_left <= r_beats_left - BL_W'(1);
    end else begin
      r_rd_valid   <= 1'b0;
      r_rd_last    <= 1'b0;
    end
  end

  assign o_rd_data       = r_rd_data;
  assign o_rd_data_valid = r_rd_valid;
  assign o_rd_data_last  = r_rd_last;
  assign o_rd_data_tag   = r_rd_tag;
  assign o_pipe_busy     = w_pipe_busy;
  assign o_cas_cfg_err   = r_cas_cfg_err;

endmodule

// File: tb/tb_sdr_cas_rd_capture.sv
// Directed bench for the read-capture stage with a beat scoreboard and latency model.
module tb_sdr_cas_rd_capture;

  localparam int DW    = 16;
  localparam int BL_W  = 3;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [2:0]       cfgCas;
  logic             rdCmd;
  logic [BL_W-1:0]  rdLen;
  logic [TAG_W-1:0] rdTag;
  logic [DW-1:0]    dqIn;
  logic [DW-1:0]    rdData;
  logic             rdValid;
  logic             rdLast;
  logic [TAG_W-1:0] rdDataTag;
  logic             pipeBusy;
  logic             cfgErr;

  typedef struct {
    int               cyc;
    logic [DW-1:0]    data;
    logic             last;
    logic [TAG_W-1:0] tag;
  } beat_t;

  beat_t expQ[$];
  int    cyc;
  int    testsRun;
  int    testsFailed;
  int    expLat;
  logic  expErr;
  int    busyStart;
  int    busyEnd;

  // Free-running controller clock.
  always #5 clk = ~clk;

  sdr_cas_rd_capture dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_cfg_sdr_cas   (cfgCas),
    .i_rd_cmd        (rdCmd),
    .i_rd_len        (rdLen),
    .i_rd_tag        (rdTag),
    .i_sdr_dq_in     (dqIn),
    .o_rd_data       (rdData),
    .o_rd_data_valid (rdValid),
    .o_rd_data_last  (rdLast),
    .o_rd_data_tag   (rdDataTag),
    .o_pipe_busy     (pipeBusy),
    .o_cas_cfg_err   (cfgErr)
  );

  // Single comparison point: counts it and reports any difference.
  task automatic check1(input string name, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    assert (got === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  // Everything the DUT drives must read zero while reset is held.
  task automatic checkResetState();
    check1("rst_data",  32'(rdData),    32'd0);
    check1("rst_valid", 32'(rdValid),   32'd0);
    check1("rst_last",  32'(rdLast),    32'd0);
    check1("rst_tag",   32'(rdDataTag), 32'd0);
    check1("rst_busy",  32'(pipeBusy),  32'd0);
    check1("rst_err",   32'(cfgErr),    32'd0);
  endtask

  // Compare this cycle's outputs with the scoreboard head and the busy/error model.
  task automatic checkOutput();
    beat_t b;
    logic  modelBusy;
    modelBusy = (cyc >= busyStart) && (cyc <= busyEnd);
    if (expQ.size() > 0 && expQ[0].cyc == cyc) begin
      b = expQ.pop_front();
      check1("valid", 32'(rdValid),   32'd1);
      check1("data",  32'(rdData),    32'(b.data));
      check1("last",  32'(rdLast),    32'(b.last));
      check1("tag",   32'(rdDataTag), 32'(b.tag));
    end else begin
      check1("idle_valid", 32'(rdValid), 32'd0);
    end
    check1("busy", 32'(pipeBusy), 32'(modelBusy));
    check1("err",  32'(cfgErr),   32'(expErr));
  endtask

  // Advance one cycle: update the latency model, move DQ, drop the command pulse, check.
  task automatic stepCycle();
    if (!reset && !rdCmd && !((cyc >= busyStart) && (cyc <= busyEnd))) begin
      if (cfgCas >= 3'd2 && cfgCas <= 3'd3) begin
        expLat = int'(cfgCas);
        expErr = 1'b0;
      end else begin
        expLat = 3;
        expErr = 1'b1;
      end
    end
    @(negedge clk);
    cyc++;
    dqIn  = 16'(32'hA000 + cyc);
    rdCmd = 1'b0;
    checkOutput();
  endtask

  task automatic runCycles(input int n);
    repeat (n) stepCycle();
  endtask

  // Issue a READ this cycle and queue the beats it should produce.
  task automatic applyStimulus(input int len, input int tag);
    int first;
    beat_t b;
    rdCmd = 1'b1;
    rdLen = BL_W'(len);
    rdTag = TAG_W'(tag);
    first = cyc + expLat + 1;
    while (expQ.size() > 0 && expQ[$].cyc >= first) void'(expQ.pop_back());
    for (int i = 0; i <= len; i++) begin
      b.cyc  = first + i;
      b.data = 16'(32'hA000 + cyc + expLat + i);
      b.last = (i == len);
      b.tag  = TAG_W'(tag);
      expQ.push_back(b);
    end
    if (cyc + 1 > busyEnd + 1) busyStart = cyc + 1;
    busyEnd = cyc + expLat + len + 1;
    stepCycle();
  endtask

  // Directed sequence covering the basic read, both latencies, chaining, interrupt, config and reset.
  initial begin
    reset = 1'b1; cfgCas = 3'd2; rdCmd = 1'b0; rdLen = '0; rdTag = '0; dqIn = '0;
    cyc = 0; testsRun = 0; testsFailed = 0;
    expLat = 3; expErr = 1'b0; busyStart = 1; busyEnd = 0;
    repeat (2) @(negedge clk);
    checkResetState();
    @(negedge clk);
    reset = 1'b0;
    cyc   = 0;
    dqIn  = 16'hA000;

    // CAS 2, read at cycle 10, four beats 0xA00C..0xA00F
    while (cyc < 10) stepCycle();
    applyStimulus(3, 5);
    runCycles(10);

    // CAS 3, same read
    cfgCas = 3'd3;
    runCycles(3);
    applyStimulus(3, 5);
    runCycles(10);

    // Back-to-back two-beat reads with gapless valid
    cfgCas = 3'd2;
    runCycles(3);
    applyStimulus(1, 1);
    runCycles(1);
    applyStimulus(1, 2);
    runCycles(10);

    // Long burst interrupted by a single-beat read
    cfgCas = 3'd3;
    runCycles(3);
    applyStimulus(7, 3);
    runCycles(2);
    applyStimulus(0, 9);
    runCycles(10);

    // Latency change while busy is ignored until idle, then illegal and legal values
    runCycles(2);
    applyStimulus(7, 4);
    runCycles(2);
    cfgCas = 3'd2;
    runCycles(2);
    applyStimulus(1, 6);
    runCycles(12);
    cfgCas = 3'd5;
    runCycles(3);
    applyStimulus(1, 7);
    runCycles(10);
    cfgCas = 3'd2;
    runCycles(3);
    applyStimulus(1, 10);
    runCycles(10);

    // Reset on the second beat of a long burst, then a fresh read
    cfgCas = 3'd3;
    runCycles(3);
    applyStimulus(7, 8);
    runCycles(4);
    reset = 1'b1;
    #1;
    checkResetState();
    expQ.delete();
    busyStart = 1; busyEnd = 0; expLat = 3; expErr = 1'b0;
    runCycles(2);
    reset = 1'b0;
    runCycles(5);
    applyStimulus(3, 5);
    runCycles(10);

    check1("queue_empty", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
